// File: rtl/mult_pipe_wrapper_if.sv
// mult_pipe_wrapper_if: handshake bundle for the pipelined multiplier.
//   master : producer/consumer side (drives operands, in_valid, out_ready)
//   slave  : multiplier side (drives in_ready, out_valid, product, in_flight)
//   in_valid/in_ready           operand handshake
//   multiplicand, multiplier    WIDTH-bit operands
//   is_signed                   1 = two's complement operands, 0 = unsigned
//   out_valid/out_ready         product handshake
//   product                     2*WIDTH-bit full-precision result
//   in_flight                   number of occupied pipeline stages
interface mult_pipe_wrapper_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
);
    localparam int unsigned CNT_W = $clog2(STAGES + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 is_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic [CNT_W-1:0]     in_flight;

    modport master (
        output in_valid, multiplicand, multiplier, is_signed, out_ready,
        input  in_ready, out_valid, product, in_flight
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, is_signed, out_ready,
        output in_ready, out_valid, product, in_flight
    );
endinterface

// File: rtl/mult_pipe_wrapper.sv
// mult_pipe_wrapper: elastic STAGES-deep multiplier pipeline.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mult_pipe_wrapper_if.slave (operand/product handshakes, in_flight)
// Stage 1 registers the operands and sign mode; the product is formed
// combinationally from stage 1 and carried through stages 2..STAGES.
// Every stage loads when empty or advancing, so bubbles collapse under stall.
module mult_pipe_wrapper #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    mult_pipe_wrapper_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(STAGES + 1);
    localparam int unsigned PW    = 2 * WIDTH;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] stage_ready;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              sgn_q, sgn_d;
    // Product registers for stages 2..STAGES (index 0 is stage 2).
    logic [PW-1:0]     prod_q [STAGES-1];
    logic [PW-1:0]     prod_d [STAGES-1];
    logic [PW-1:0]     ext_a, ext_b, stage1_prod;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept, deliver;

    // Ready ripples back from the consumer: a stage can load if it is empty
    // or everything from it to the output can move this cycle.
    always_comb begin
        logic rdy;
        rdy         = bus.out_ready;
        stage_ready = '0;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            rdy            = !vld_q[i] || rdy;
            stage_ready[i] = rdy;
        end
    end

    // Extending both operands to 2*WIDTH makes the truncated product exact
    // for either signedness.
    always_comb begin
        ext_a       = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
        ext_b       = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
        stage1_prod = ext_a * ext_b;
    end

    assign accept  = bus.in_valid && stage_ready[0];
    assign deliver = vld_q[STAGES-1] && bus.out_ready;

    always_comb begin
        vld_d  = vld_q;
        a_d    = a_q;
        b_d    = b_q;
        sgn_d  = sgn_q;
        prod_d = prod_q;
        if (stage_ready[0]) begin
            vld_d[0] = bus.in_valid;
        end
        if (accept) begin
            a_d   = bus.multiplicand;
            b_d   = bus.multiplier;
            sgn_d = bus.is_signed;
        end
        if (stage_ready[1]) begin
            vld_d[1]  = vld_q[0];
            prod_d[0] = stage1_prod;
        end
        for (int i = 2; i < int'(STAGES); i++) begin
            if (stage_ready[i]) begin
                vld_d[i]    = vld_q[i-1];
                prod_d[i-1] = prod_q[i-2];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({accept, deliver})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            cnt_q <= '0;
            for (int i = 0; i < int'(STAGES) - 1; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            a_q    <= a_d;
            b_q    <= b_d;
            sgn_q  <= sgn_d;
            cnt_q  <= cnt_d;
            prod_q <= prod_d;
        end
    end

    assign bus.in_ready  = stage_ready[0];
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.product   = vld_q[STAGES-1] ? prod_q[STAGES-2] : '0;
    assign bus.in_flight = cnt_q;
endmodule

// File: tb/tb_mult_pipe_wrapper.sv
// Bench for mult_pipe_wrapper: two instances (8-bit/2-stage and
// 16-bit/4-stage) checked every cycle against a queue-based model, plus
// directed corner cases with literal expected products.
module tb_mult_pipe_wrapper;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_pipe_wrapper_if #(.WIDTH(8),  .STAGES(2)) b8  ();
    mult_pipe_wrapper_if #(.WIDTH(16), .STAGES(4)) b16 ();

    mult_pipe_wrapper #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8.slave)
    );

    mult_pipe_wrapper #(.WIDTH(16), .STAGES(4)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b16.slave)
    );

    typedef struct {
        logic [63:0] p;
        int          acc;
    } ent_t;

    ent_t q8[$];
    ent_t q16[$];
    int   cyc    = 0;
    int   last8  = -100;
    int   last16 = -100;
    int   hs8    = 0;
    int   hs16   = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Mathematical product: interpret operands as integers, multiply, wrap to 2*w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input int w);
        longint x, y, p;
        logic [63:0] r;
        x = longint'(a);
        y = longint'(b);
        if (s && a[w-1]) x = x - (longint'(1) << w);
        if (s && b[w-1]) y = y - (longint'(1) << w);
        p = x * y;
        r = p;
        return r & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Per-cycle compare against the model. An entry reaches the output no
    // earlier than STAGES cycles after its accept and no earlier than the
    // cycle after the previous output was taken.
    always @(negedge clk) begin
        logic exp_v;
        cyc++;
        if (!rst_n) begin
            q8.delete();
            q16.delete();
            last8  = -100;
            last16 = -100;
            chk("rst_v8",   b8.out_valid,  0);
            chk("rst_p8",   b8.product,    0);
            chk("rst_f8",   b8.in_flight,  0);
            chk("rst_v16",  b16.out_valid, 0);
            chk("rst_p16",  b16.product,   0);
            chk("rst_f16",  b16.in_flight, 0);
        end else begin
            exp_v = (q8.size() > 0) && (cyc >= q8[0].acc + 2) && (cyc >= last8 + 1);
            chk("valid8", b8.out_valid, exp_v);
            chk("ready8", b8.in_ready, (q8.size() < 2) || b8.out_ready);
            chk("flight8", b8.in_flight, q8.size());
            if (b8.out_valid && q8.size() > 0) chk("prod8", b8.product, q8[0].p);
            else if (!b8.out_valid) chk("prod8_zero", b8.product, 0);
            if (b8.out_valid && b8.out_ready && q8.size() > 0) begin
                void'(q8.pop_front());
                last8 = cyc;
                hs8++;
            end
            if (b8.in_valid && b8.in_ready)
                q8.push_back('{ref_mul(32'(b8.multiplicand), 32'(b8.multiplier),
                                       b8.is_signed, 8), cyc});

            exp_v = (q16.size() > 0) && (cyc >= q16[0].acc + 4) && (cyc >= last16 + 1);
            chk("valid16", b16.out_valid, exp_v);
            chk("ready16", b16.in_ready, (q16.size() < 4) || b16.out_ready);
            chk("flight16", b16.in_flight, q16.size());
            if (b16.out_valid && q16.size() > 0) chk("prod16", b16.product, q16[0].p);
            else if (!b16.out_valid) chk("prod16_zero", b16.product, 0);
            if (b16.out_valid && b16.out_ready && q16.size() > 0) begin
                void'(q16.pop_front());
                last16 = cyc;
                hs16++;
            end
            if (b16.in_valid && b16.in_ready)
                q16.push_back('{ref_mul(32'(b16.multiplicand), 32'(b16.multiplier),
                                        b16.is_signed, 16), cyc});
        end
    end

    // Present one transaction and return just after the accepting edge; in_valid stays high.
    task automatic push8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int t = 0;
        b8.multiplicand = a;
        b8.multiplier   = b;
        b8.is_signed    = s;
        b8.in_valid     = 1'b1;
        @(negedge clk);
        while (!b8.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("push8_timeout", b8.in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic push16(input logic [15:0] a, input logic [15:0] b, input logic s);
        int t = 0;
        b16.multiplicand = a;
        b16.multiplier   = b;
        b16.is_signed    = s;
        b16.in_valid     = 1'b1;
        @(negedge clk);
        while (!b16.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("push16_timeout", b16.in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic dir8(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [15:0] exp);
        int lat;
        b8.out_ready = 1'b1;
        push8(a, b, s);
        b8.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!b8.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, lat, 2);
        chk(nm, b8.product, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic dir16(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [31:0] exp);
        int lat;
        b16.out_ready = 1'b1;
        push16(a, b, s);
        b16.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!b16.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, lat, 4);
        chk(nm, b16.product, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        b8.in_valid   = 1'b0;
        b16.in_valid  = 1'b0;
        b8.out_ready  = 1'b1;
        b16.out_ready = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;
        int          hs_start;

        b8.in_valid = 0;  b8.multiplicand = 0;  b8.multiplier = 0;  b8.is_signed = 0;
        b8.out_ready = 1;
        b16.in_valid = 0; b16.multiplicand = 0; b16.multiplier = 0; b16.is_signed = 0;
        b16.out_ready = 1;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready8", b8.in_ready, 1);
        chk("reset_in_ready16", b16.in_ready, 1);
        @(posedge clk);
        #1;

        // Unsigned and signed corners, 8-bit.
        dir8("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        dir8("u_00_ab", 8'h00, 8'hAB, 1'b0, 16'h0000);
        dir8("s_80_80", 8'h80, 8'h80, 1'b1, 16'h4000);
        dir8("s_ff_ff", 8'hFF, 8'hFF, 1'b1, 16'h0001);
        dir8("s_80_01", 8'h80, 8'h01, 1'b1, 16'hFF80);
        dir8("s_7f_80", 8'h7F, 8'h80, 1'b1, 16'hC080);
        idle_cycles(2);

        // Throughput: 16 back-to-back with alternating sign mode.
        hs_start = hs8;
        for (int i = 0; i < 16; i++)
            push8(8'($urandom), 8'($urandom), 1'(i % 2));
        b8.in_valid = 1'b0;
        idle_cycles(4);
        chk("tput_count", hs8 - hs_start, 16);

        // Backpressure: two fill the pipe, third waits.
        b8.out_ready = 1'b0;
        push8(8'h12, 8'h34, 1'b0);
        push8(8'hF0, 8'h0F, 1'b1);
        b8.multiplicand = 8'h55;
        b8.multiplier   = 8'hAA;
        b8.is_signed    = 1'b0;
        @(negedge clk);
        held = b8.product;
        chk("bp_ready", b8.in_ready, 0);
        chk("bp_flight", b8.in_flight, 2);
        chk("bp_valid", b8.out_valid, 1);
        chk("bp_first", held, 16'h03A8);
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold", b8.product, held);
            chk("bp_ready_hold", b8.in_ready, 0);
        end
        @(posedge clk);
        #1 b8.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", b8.in_ready, 1);
        @(posedge clk);
        #1 b8.in_valid = 1'b0;
        idle_cycles(4);

        // Reset with two in flight.
        b8.out_ready = 1'b0;
        push8(8'h9C, 8'h3D, 1'b1);
        push8(8'h21, 8'h42, 1'b0);
        b8.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", b8.out_valid, 0);
        chk("mid_rst_product", b8.product, 0);
        chk("mid_rst_flight", b8.in_flight, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        b8.out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("no_stale", b8.out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Randomised traffic, 8-bit.
        for (int n = 0; n < 400; n++) begin
            b8.in_valid     = 1'($urandom_range(0, 1));
            b8.multiplicand = 8'($urandom);
            b8.multiplier   = 8'($urandom);
            b8.is_signed    = 1'($urandom_range(0, 1));
            b8.out_ready    = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        idle_cycles(4);

        // 16-bit / 4-stage corners.
        dir16("w_s_8000", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        dir16("w_u_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
        dir16("w_s_ffff", 16'hFFFF, 16'h7FFF, 1'b1, 32'hFFFF_8001);
        idle_cycles(2);

        // Fill under stall: four held, then drain.
        b16.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push16(16'($urandom), 16'($urandom), 1'(i % 2));
        b16.in_valid = 1'b0;
        @(negedge clk);
        chk("w_full_flight", b16.in_flight, 4);
        chk("w_full_ready", b16.in_ready, 0);
        @(posedge clk);
        #1;
        idle_cycles(6);

        // Randomised traffic, 16-bit.
        for (int n = 0; n < 400; n++) begin
            b16.in_valid     = 1'($urandom_range(0, 1));
            b16.multiplicand = 16'($urandom);
            b16.multiplier   = 16'($urandom);
            b16.is_signed    = 1'($urandom_range(0, 1));
            b16.out_ready    = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        idle_cycles(8);
        chk("drained8", q8.size(), 0);
        chk("drained16", q16.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
